// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: sequencer state encoding and
// the default operand width.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_bit_counter.sv
// Bit index counter for the serial adder: walks 0..WIDTH-1 while enabled and
// flags the last bit so the sequencer knows when the add completes.
module serial_bit_counter #(
  parameter int WIDTH = serial_pkg::DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  assign idx_o  = idx_q;
  assign last_o = (idx_q == IDX_W'(WIDTH - 1));

  // Clear wins over enable so a fresh add always starts at bit 0.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = last_o ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/bitserial_add_sequencer.sv
// Bit-serial adder sequencer: latches two operands, adds them LSB first one
// bit per cycle, and exposes the per-bit slice signals for a downstream slice.
module bitserial_add_sequencer
  import serial_pkg::*;
#(
  parameter int UUID  = 0,
  parameter     NAME  = "",
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Input_A,
  input  logic [WIDTH-1:0] Input_B,
  input  logic             Overwrite,
  input  logic [WIDTH-1:0] Overwrite_value,
  output logic             Busy,
  output logic             Done,
  output logic             Bit,
  output logic             Carry,
  output logic             Overrite_bit,
  output logic             Overite,
  output logic [WIDTH-1:0] Result,
  output logic             Carry_out
);

  localparam int IDX_W = $clog2(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] ovv_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] result_q;
  logic             ov_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic [IDX_W-1:0] idx;
  logic             last;
  logic             in_run;
  logic             accept;
  logic             a_bit;
  logic             b_bit;
  logic             ovv_bit;
  logic             res_bit;
  logic             carry_d;

  assign in_run  = (state_q == RUN);
  assign accept  = (state_q == IDLE) && Start;

  assign a_bit   = a_q[idx];
  assign b_bit   = b_q[idx];
  assign ovv_bit = ovv_q[idx];
  assign carry_d = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
  assign res_bit = ov_q ? ovv_bit : (a_bit ^ b_bit ^ carry_q);

  // Complete sum including the bit being finished this cycle, so Result can be
  // published in one step and stays untouched while the next add runs.
  always_comb begin
    sum_d      = sum_q;
    sum_d[idx] = res_bit;
  end

  serial_bit_counter #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (accept),
    .en_i    (in_run),
    .idx_o   (idx),
    .last_o  (last)
  );

  assign Bit          = in_run & (a_bit ^ b_bit);
  assign Carry        = in_run & carry_q;
  assign Overrite_bit = in_run & ovv_bit;
  assign Overite      = in_run & ov_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Result       = result_q;
  assign Carry_out    = cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ovv_q    <= '0;
      sum_q    <= '0;
      result_q <= '0;
      ov_q     <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            a_q     <= Input_A;
            b_q     <= Input_B;
            ovv_q   <= Overwrite_value;
            ov_q    <= Overwrite;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          if (last) begin
            result_q <= sum_d;
            cout_q   <= ov_q ? 1'b0 : carry_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_add_sequencer.sv
// Self-checking bench for bitserial_add_sequencer at WIDTH=8, comparing
// against an arithmetic reference of the serial add.
module tb_bitserial_add_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [W-1:0] Input_A;
  logic [W-1:0] Input_B;
  logic         Overwrite;
  logic [W-1:0] Overwrite_value;
  logic         Busy;
  logic         Done;
  logic         Bit;
  logic         Carry;
  logic         Overrite_bit;
  logic         Overite;
  logic [W-1:0] Result;
  logic         Carry_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         done_k;
    int         n_done;
    logic [7:0] res;
    logic       cout;
    logic [7:0] bits;
    logic [7:0] cars;
    logic [7:0] obits;
    logic [7:0] ovs;
    logic [8:0] busy;
    logic [3:0] side9;
    logic       busy_after;
    logic [7:0] res_after;
    logic       cout_after;
  } obs_t;

  always #5 clk = ~clk;

  bitserial_add_sequencer #(
    .UUID  (1),
    .NAME  ("tb"),
    .WIDTH (W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .Start           (Start),
    .Input_A         (Input_A),
    .Input_B         (Input_B),
    .Overwrite       (Overwrite),
    .Overwrite_value (Overwrite_value),
    .Busy            (Busy),
    .Done            (Done),
    .Bit             (Bit),
    .Carry           (Carry),
    .Overrite_bit    (Overrite_bit),
    .Overite         (Overite),
    .Result          (Result),
    .Carry_out       (Carry_out)
  );

  // Carry into each bit position, taken from plain addition of the low bits.
  function automatic logic [7:0] ref_carries(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      int m;
      m = (1 << i) - 1;
      c[i] = ((((int'(a) & m) + (int'(b) & m)) >> i) & 1) != 0;
    end
    return c;
  endfunction

  // Issues one Start at the current negedge and records 12 cycles of outputs.
  // Inputs are scrambled while the add runs to show they are not re-sampled.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ow,
                       input logic [7:0] owv, output obs_t o);
    o.done_k = -1; o.n_done = 0; o.res = '0; o.cout = 1'b0;
    o.bits = '0; o.cars = '0; o.obits = '0; o.ovs = '0; o.busy = '0;
    o.side9 = '0; o.busy_after = 1'b1; o.res_after = '0; o.cout_after = 1'b0;
    Input_A = a; Input_B = b; Overwrite = ow; Overwrite_value = owv; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      Input_A = 8'($urandom); Input_B = 8'($urandom);
      Overwrite = 1'($urandom); Overwrite_value = 8'($urandom);
      @(negedge clk);
      if (k <= 8) begin
        o.bits[k-1] = Bit; o.cars[k-1] = Carry;
        o.obits[k-1] = Overrite_bit; o.ovs[k-1] = Overite;
      end
      if (k <= 9) o.busy[k-1] = Busy;
      if (k == 9) o.side9 = {Bit, Carry, Overrite_bit, Overite};
      if (k == 10) o.busy_after = Busy;
      if (k == 12) begin o.res_after = Result; o.cout_after = Carry_out; end
      if (Done) begin
        o.n_done++;
        if (o.done_k < 0) begin o.done_k = k; o.res = Result; o.cout = Carry_out; end
      end
    end
  endtask

  task automatic test_op(input logic [7:0] a, input logic [7:0] b, input logic ow,
                         input logic [7:0] owv);
    obs_t       o;
    int         sum;
    logic [7:0] exp_res;
    logic       exp_cout;
    logic [7:0] exp_cars;
    sum      = int'(a) + int'(b);
    exp_res  = ow ? owv : 8'(sum % 256);
    exp_cout = ow ? 1'b0 : (sum >= 256);
    exp_cars = ref_carries(a, b);
    do_op(a, b, ow, owv, o);
    $display("op a=%02h b=%02h ow=%0d owv=%02h -> done@%0d result=%02h cout=%0d",
             a, b, ow, owv, o.done_k, o.res, o.cout);
    n_cmp++; if (o.done_k !== 9) begin n_err++; $display("FAIL latency: got %0d want 9", o.done_k); end
    n_cmp++; if (o.n_done !== 1) begin n_err++; $display("FAIL done_count: got %0d want 1", o.n_done); end
    n_cmp++; if (o.res !== exp_res) begin n_err++; $display("FAIL result: got %02h want %02h", o.res, exp_res); end
    n_cmp++; if (o.cout !== exp_cout) begin n_err++; $display("FAIL carry_out: got %0d want %0d", o.cout, exp_cout); end
    n_cmp++; if (o.bits !== (a ^ b)) begin n_err++; $display("FAIL bit_stream: got %02h want %02h", o.bits, a ^ b); end
    n_cmp++; if (o.cars !== exp_cars) begin n_err++; $display("FAIL carry_stream: got %02h want %02h", o.cars, exp_cars); end
    n_cmp++; if (o.obits !== owv) begin n_err++; $display("FAIL ovbit_stream: got %02h want %02h", o.obits, owv); end
    n_cmp++; if (o.ovs !== {8{ow}}) begin n_err++; $display("FAIL ov_stream: got %02h want %02h", o.ovs, {8{ow}}); end
    n_cmp++; if (o.busy !== 9'h1FF) begin n_err++; $display("FAIL busy_run: got %03h want 1ff", o.busy); end
    n_cmp++; if (o.side9 !== 4'h0) begin n_err++; $display("FAIL slice_outside_run: got %h want 0", o.side9); end
    n_cmp++; if (o.busy_after !== 1'b0) begin n_err++; $display("FAIL busy_idle: got %0d want 0", o.busy_after); end
    n_cmp++; if (o.res_after !== exp_res || o.cout_after !== exp_cout) begin
      n_err++; $display("FAIL result_hold: got %02h/%0d want %02h/%0d", o.res_after, o.cout_after, exp_res, exp_cout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b1; Input_A = 8'h12; Input_B = 8'h34;
    Overwrite = 1'b0; Overwrite_value = 8'h00;
    repeat (3) @(negedge clk);
    $display("reset: busy=%0d done=%0d result=%02h cout=%0d", Busy, Done, Result, Carry_out);
    n_cmp++; if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_err++; $display("FAIL reset_status: got busy=%0d done=%0d want 0/0", Busy, Done);
    end
    n_cmp++; if (Result !== 8'h00 || Carry_out !== 1'b0) begin
      n_err++; $display("FAIL reset_result: got %02h/%0d want 00/0", Result, Carry_out);
    end
    n_cmp++; if ({Bit, Carry, Overrite_bit, Overite} !== 4'h0) begin
      n_err++; $display("FAIL reset_slice: got %h want 0", {Bit, Carry, Overrite_bit, Overite});
    end
    rst = 1'b0; Start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'h0F, 8'hFF, 8'hFF, 8'h80};
    logic [7:0] tb [4] = '{8'h01, 8'h01, 8'hFF, 8'h80};
    logic       tw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] tv [4] = '{8'h00, 8'h00, 8'hA5, 8'h3C};
    for (int i = 0; i < 4; i++) test_op(ta[i], tb[i], tw[i], tv[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      test_op(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
  endtask

  task automatic test_start_ignored();
    int         dk = -1;
    int         nd = 0;
    logic [7:0] res = '0;
    logic       cout = 1'b0;
    Input_A = 8'h3C; Input_B = 8'h5A; Overwrite = 1'b0; Overwrite_value = 8'h00; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (Done) begin nd++; if (dk < 0) begin dk = k; res = Result; cout = Carry_out; end end
      if (k == 4) begin Start = 1'b1; Input_A = 8'h00; Input_B = 8'h77; end
      if (k == 5) Start = 1'b0;
    end
    $display("restart-ignored: done@%0d dones=%0d result=%02h cout=%0d", dk, nd, res, cout);
    n_cmp++; if (nd !== 1 || dk !== 9) begin n_err++; $display("FAIL restart_done: got %0d dones @%0d want 1 @9", nd, dk); end
    n_cmp++; if (res !== 8'h96 || cout !== 1'b0) begin n_err++; $display("FAIL restart_result: got %02h/%0d want 96/0", res, cout); end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    Input_A = 8'hC3; Input_B = 8'h61; Overwrite = 1'b0; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-run: busy=%0d done=%0d result=%02h cout=%0d", Busy, Done, Result, Carry_out);
    n_cmp++; if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_err++; $display("FAIL midrst_status: got busy=%0d done=%0d want 0/0", Busy, Done);
    end
    n_cmp++; if (Result !== 8'h00 || Carry_out !== 1'b0) begin
      n_err++; $display("FAIL midrst_result: got %02h/%0d want 00/0", Result, Carry_out);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (Done || Busy) nd++;
    end
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL midrst_quiet: got %0d active cycles want 0", nd); end
    test_op(8'hC3, 8'h61, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [5];
    logic [7:0] ob [5];
    for (int j = 0; j < 5; j++) begin oa[j] = 8'($urandom); ob[j] = 8'($urandom); end
    Input_A = oa[0]; Input_B = ob[0]; Overwrite = 1'b0; Start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 5; j++) begin
      int         dk = -1;
      int         sum;
      logic [7:0] res = '0;
      logic       cout = 1'b0;
      #1;
      if (j < 4) begin Input_A = oa[j+1]; Input_B = ob[j+1]; end
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (Done) begin dk = k; res = Result; cout = Carry_out; break; end
      end
      if (j == 4) Start = 1'b0;
      @(negedge clk);
      sum = int'(oa[j]) + int'(ob[j]);
      $display("b2b op%0d a=%02h b=%02h -> done@%0d result=%02h cout=%0d", j, oa[j], ob[j], dk, res, cout);
      n_cmp++; if (dk !== 9) begin n_err++; $display("FAIL b2b_period: got %0d want 9", dk); end
      n_cmp++; if (res !== 8'(sum % 256) || cout !== (sum >= 256)) begin
        n_err++; $display("FAIL b2b_result: got %02h/%0d want %02h/%0d", res, cout, 8'(sum % 256), sum >= 256);
      end
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy=%0d want 0", Busy); end
      if (j < 4) @(posedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; Start = 1'b0; Input_A = '0; Input_B = '0;
    Overwrite = 1'b0; Overwrite_value = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
